// File: rtl/spi_master_arbiter.sv
// Round-robin sequencer sharing one SPI byte engine between NREQ requesters,
// with locked multi-byte bursts and a per-byte watchdog.
module spi_master_arbiter #(
   parameter int NREQ   = 4,
   parameter int TO_CYC = 1024,
   parameter int PW     = 2
) (
   input  logic                clk,
   input  logic                rstb,
   input  logic [NREQ-1:0]     req,
   input  logic [NREQ-1:0]     last,
   input  logic [8*NREQ-1:0]   wdat,
   input  logic [2*NREQ-1:0]   cfg_cdiv,
   input  logic [NREQ-1:0]     cfg_mlb,
   output logic [NREQ-1:0]     gnt,
   output logic [NREQ-1:0]     ack,
   output logic [NREQ-1:0]     err,
   output logic [7:0]          rdat,
   output logic                busy,
   output logic                m_start,
   output logic [7:0]          m_tdat,
   output logic [1:0]          m_cdiv,
   output logic                m_mlb,
   input  logic                m_done,
   input  logic [7:0]          m_rdata
);

   localparam int WW = $clog2(TO_CYC + 1);

   typedef enum logic [1:0] {IDLE, LOAD, WAIT, HOLD} state_t;

   state_t          state;
   logic [PW-1:0]   ptr;
   logic [PW-1:0]   g;
   logic            l_last;
   logic            m_done_q;
   logic [WW-1:0]   wd;
   logic            done_rise;
   logic [PW-1:0]   win;
   logic            any;

   logic [7:0]      wbyte [NREQ];
   logic [1:0]      cdiv_a [NREQ];

   for (genvar i = 0; i < NREQ; i++) begin : g_unpack
      assign wbyte[i]  = wdat[8*i +: 8];
      assign cdiv_a[i] = cfg_cdiv[2*i +: 2];
   end

   assign done_rise = m_done & ~m_done_q;

   function automatic logic [NREQ-1:0] onehot(input logic [PW-1:0] i);
      logic [NREQ-1:0] oh;
      oh    = '0;
      oh[i] = 1'b1;
      return oh;
   endfunction

   function automatic logic [PW-1:0] inc_ptr(input logic [PW-1:0] p);
      if (p == PW'(NREQ - 1)) return '0;
      return p + 1'b1;
   endfunction

   // Descending scan so the requester closest at-or-after ptr is written last.
   always_comb begin
      int idx;
      idx = 0;
      win = ptr;
      any = 1'b0;
      for (int k = NREQ - 1; k >= 0; k--) begin
         idx = int'(ptr) + k;
         if (idx >= NREQ) idx = idx - NREQ;
         if (req[idx[PW-1:0]]) begin
            win = idx[PW-1:0];
            any = 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rstb) begin
         state    <= IDLE;
         ptr      <= '0;
         g        <= '0;
         l_last   <= 1'b0;
         m_done_q <= 1'b0;
         wd       <= '0;
         gnt      <= '0;
         ack      <= '0;
         err      <= '0;
         rdat     <= '0;
         busy     <= 1'b0;
         m_start  <= 1'b0;
         m_tdat   <= '0;
         m_cdiv   <= '0;
         m_mlb    <= 1'b0;
      end else begin
         m_done_q <= m_done;
         ack      <= '0;
         err      <= '0;
         m_start  <= 1'b0;
         case (state)
            IDLE: begin
               if (any) begin
                  g       <= win;
                  gnt     <= onehot(win);
                  busy    <= 1'b1;
                  m_tdat  <= wbyte[win];
                  m_cdiv  <= cdiv_a[win];
                  m_mlb   <= cfg_mlb[win];
                  l_last  <= last[win];
                  m_start <= 1'b1;
                  state   <= LOAD;
               end
            end
            LOAD: begin
               wd    <= '0;
               state <= WAIT;
            end
            WAIT: begin
               // A completion on the expiry cycle still counts as success.
               if (done_rise) begin
                  rdat <= m_rdata;
                  ack  <= onehot(g);
                  wd   <= '0;
                  if (l_last) begin
                     state <= IDLE;
                     gnt   <= '0;
                     busy  <= 1'b0;
                     ptr   <= inc_ptr(g);
                  end else begin
                     state <= HOLD;
                  end
               end else if (wd == WW'(TO_CYC - 1)) begin
                  err   <= onehot(g);
                  state <= IDLE;
                  gnt   <= '0;
                  busy  <= 1'b0;
                  ptr   <= inc_ptr(g);
               end else begin
                  wd <= wd + 1'b1;
               end
            end
            HOLD: begin
               if (req[g]) begin
                  m_tdat  <= wbyte[g];
                  m_cdiv  <= cdiv_a[g];
                  m_mlb   <= cfg_mlb[g];
                  l_last  <= last[g];
                  m_start <= 1'b1;
                  state   <= LOAD;
               end else begin
                  state <= IDLE;
                  gnt   <= '0;
                  busy  <= 1'b0;
                  ptr   <= inc_ptr(g);
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
